sram_read_arbiter: RTL and testbench
====================================

// Module: sram_read_arbiter
// PURPOSE
//  Shares the single read-only 16-bit board SRAM between two requesters. Port A is the audio sample streamer. Port C is the step-chart fetcher that feeds arrow scheduling.
//  Owns all SRAM control strobes, the address bus and read timing. Requesters see a req/ack handshake with registered read data.
//  Sits between the SRAM pins and the audio/chart front-ends; replaces direct SRAM driving by a single reader.
// PARAMETERS
//  ADDR_W      20  SRAM word-address width
//  DATA_W      16  SRAM data width
//  WAIT_CYCLES 2   Clk cycles SRAM_OE_N is held low per read (>=1)
//  STARVE_MAX  4   consecutive A-wins over a pending C before C is forced (>=1)
// PORTS
//  Clk          in   1       system clock (50 MHz)
//  reset        in   1       synchronous, active-high
//  a_req        in   1       audio read request (level)
//  a_addr       in   ADDR_W  audio word address
//  a_ack        out  1       one-cycle pulse: a_data valid
//  a_data       out  DATA_W  audio read data (held until next A ack)
//  c_req        in   1       chart read request (level)
//  c_addr       in   ADDR_W  chart word address
//  c_ack        out  1       one-cycle pulse: c_data valid
//  c_data       out  DATA_W  chart read data (held until next C ack)
//  SRAM_DQ      in   DATA_W  SRAM data bus (read only)
//  SRAM_ADDR    out  ADDR_W  SRAM address
//  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM strobes, active-low
//  a_grants, c_grants, conflicts  out  16 each  statistics (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; all strobes 1; SRAM_ADDR=0; acks 0; a_data=c_data=0; starve_cnt=0; stats 0.
//  Reset during an access aborts it: no ack issued, strobes 1 on the next edge.
//  SRAM_WE_N is constant 1. CE_N/OE_N/UB_N/LB_N are 0 only in ACCESS. All outputs are registered.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: if any req, pick winner, latch its addr into SRAM_ADDR, latch grant id, wait_cnt=0, go ACCESS.
//   ACCESS: strobes low for exactly WAIT_CYCLES cycles. On the last cycle, capture SRAM_DQ into winner's data reg, go DONE.
//   DONE: winner's ack=1 for this one cycle; strobes 1; go IDLE.
//  Latency: req sampled high in IDLE at edge k -> ack high in cycle k+WAIT_CYCLES+1. Min period between acks = WAIT_CYCLES+2.
//  Arbitration: A has fixed priority, except C wins when c_req && starve_cnt==STARVE_MAX.
//  starve_cnt: +1 (saturating) when A is granted while c_req=1; cleared when C is granted or c_req=0 in IDLE.
//  Handshake: addr and req are sampled only at the grant edge. Later changes, or req dropping, do not abort; ack still fires.
//   Req still high in IDLE after DONE counts as a new request. Requesters drop req the cycle after ack.
//  Only one ack is ever high in a cycle. The losing port's data reg is untouched.
// CONFIGURATION
//  Macro SRAM_ARB_STATS_EN.
//  Defined: a_grants and c_grants count grants per port. conflicts counts IDLE cycles with a_req && c_req.
//   All three saturate at 16'hFFFF and clear on reset.
//  Undefined: the three ports stay present and are tied to 0; no counter logic is built.
// STRUCTURE
//  sram_arb_pkg:
//   typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t
//   typedef enum logic {PORT_A, PORT_C} arb_port_t
//   localparams SRAM_ADDR_W=20, SRAM_DATA_W=16
//  Sub-module sram_arb_sat_counter (16-bit saturating, enable input): instantiated x3, only under SRAM_ARB_STATS_EN.
//  FSM, wait counter, starve counter and data regs are inline.
// TESTING
//  1 Solo A: a_req=1, a_addr=20'h00010, SRAM_DQ=16'hBEEF during access.
//    -> SRAM_ADDR=20'h00010, OE_N low 2 cycles, a_ack at k+3, a_data=16'hBEEF, c_ack never.
//  2 Simultaneous: a_req=c_req=1 held, addrs 20'h1/20'h2.
//    -> A granted 4 times, then C on the 5th grant (STARVE_MAX=4), then A again. conflicts increments (STATS_EN).
//  3 Mid-access reset: assert reset in 2nd ACCESS cycle.
//    -> next cycle all strobes 1, state IDLE, no ack, a_data unchanged at 0.
//  4 Req drop: c_req high 1 cycle only, c_addr=20'h0ABCD, then changed to 20'h0.
//    -> SRAM_ADDR stays 20'h0ABCD, c_ack fires once, no second access.
//  5 Back-to-back A: a_req held 3 accesses.
//    -> acks exactly 4 cycles apart (WAIT_CYCLES=2), strobes high in each DONE cycle, WE_N always 1.
//  6 Stats saturation (STATS_EN, force a_grants=16'hFFFE): two A grants -> a_grants=16'hFFFF, holds.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM read arbiter.
package sram_arb_pkg;

    localparam int unsigned SRAM_ADDR_W = 20;
    localparam int unsigned SRAM_DATA_W = 16;
    localparam int unsigned STAT_W      = 16;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
    typedef enum logic {PORT_A, PORT_C} arb_port_t;

endpackage

// File: rtl/sram_arb_sat_counter.sv
// Saturating statistics counter; holds at all-ones until reset.
module sram_arb_sat_counter
    import sram_arb_pkg::*;
(
    input  logic              Clk,
    input  logic              reset,
    input  logic              en,
    output logic [STAT_W-1:0] count_q
);

    always_ff @(posedge Clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (en && (count_q != {STAT_W{1'b1}})) begin
            count_q <= count_q + STAT_W'(1);
        end
    end

endmodule

// File: rtl/sram_read_arbiter.sv
// Two-port (audio A / chart C) arbiter owning the read-only board SRAM.
// Optional statistics counters are built only when SRAM_ARB_STATS_EN is defined.
module sram_read_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = SRAM_ADDR_W,
    parameter int unsigned DATA_W      = SRAM_DATA_W,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_data,
    input  logic              c_req,
    input  logic [ADDR_W-1:0] c_addr,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_data,
    input  logic [DATA_W-1:0] SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic [STAT_W-1:0] a_grants,
    output logic [STAT_W-1:0] c_grants,
    output logic [STAT_W-1:0] conflicts
);

    localparam int unsigned WAIT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_t            state_q, state_d;
    arb_port_t             grant_q, grant_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic [DATA_W-1:0]     a_data_q, a_data_d, c_data_q, c_data_d;
    logic                  a_ack_q, a_ack_d, c_ack_q, c_ack_d;
    logic                  strobe_n_q;
    logic                  c_wins;

    // C wins when A is idle or C has been passed over STARVE_MAX times in a row
    assign c_wins = c_req && (!a_req || (starve_q == STARVE_W'(STARVE_MAX)));

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        wait_d   = wait_q;
        starve_d = starve_q;
        a_data_d = a_data_q;
        c_data_d = c_data_q;
        a_ack_d  = 1'b0;
        c_ack_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!c_req) begin
                    starve_d = '0;
                end
                if (a_req || c_req) begin
                    if (c_wins) begin
                        grant_d  = PORT_C;
                        addr_d   = c_addr;
                        starve_d = '0;
                    end else begin
                        grant_d = PORT_A;
                        addr_d  = a_addr;
                        if (c_req) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
                    end
                    wait_d  = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_q == WAIT_W'(WAIT_CYCLES - 1)) begin
                    state_d = DONE;
                    if (grant_q == PORT_C) begin
                        c_data_d = SRAM_DQ;
                        c_ack_d  = 1'b1;
                    end else begin
                        a_data_d = SRAM_DQ;
                        a_ack_d  = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= PORT_A;
            addr_q     <= '0;
            wait_q     <= '0;
            starve_q   <= '0;
            a_data_q   <= '0;
            c_data_q   <= '0;
            a_ack_q    <= 1'b0;
            c_ack_q    <= 1'b0;
            strobe_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            wait_q     <= wait_d;
            starve_q   <= starve_d;
            a_data_q   <= a_data_d;
            c_data_q   <= c_data_d;
            a_ack_q    <= a_ack_d;
            c_ack_q    <= c_ack_d;
            strobe_n_q <= (state_d != ACCESS);
        end
    end

    assign a_ack     = a_ack_q;
    assign c_ack     = c_ack_q;
    assign a_data    = a_data_q;
    assign c_data    = c_data_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_CE_N = strobe_n_q;
    assign SRAM_OE_N = strobe_n_q;
    assign SRAM_UB_N = strobe_n_q;
    assign SRAM_LB_N = strobe_n_q;
    assign SRAM_WE_N = 1'b1;

`ifdef SRAM_ARB_STATS_EN
    logic idle_c;
    assign idle_c = (state_q == IDLE);

    sram_arb_sat_counter u_a_grants (
        .Clk     (Clk),
        .reset   (reset),
        .en      (idle_c && a_req && !c_wins),
        .count_q (a_grants)
    );

    sram_arb_sat_counter u_c_grants (
        .Clk     (Clk),
        .reset   (reset),
        .en      (idle_c && c_wins),
        .count_q (c_grants)
    );

    sram_arb_sat_counter u_conflicts (
        .Clk     (Clk),
        .reset   (reset),
        .en      (idle_c && a_req && c_req),
        .count_q (conflicts)
    );
`else
    assign a_grants  = '0;
    assign c_grants  = '0;
    assign conflicts = '0;
`endif

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed bench for sram_read_arbiter with a cycle-scheduled transaction model.
module tb_sram_read_arbiter;

    localparam int W  = 2;
    localparam int SM = 4;

    logic        Clk = 1'b0;
    logic        reset;
    logic        a_req, c_req;
    logic [19:0] a_addr, c_addr;
    logic        a_ack, c_ack;
    logic [15:0] a_data, c_data;
    logic [15:0] SRAM_DQ;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
    logic [15:0] a_grants, c_grants, conflicts;

    int n_chk  = 0;
    int n_fail = 0;

    sram_read_arbiter dut (
        .Clk       (Clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_ack     (a_ack),
        .a_data    (a_data),
        .c_req     (c_req),
        .c_addr    (c_addr),
        .c_ack     (c_ack),
        .c_data    (c_data),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_OE_N (SRAM_OE_N),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_UB_N (SRAM_UB_N),
        .SRAM_LB_N (SRAM_LB_N),
        .a_grants  (a_grants),
        .c_grants  (c_grants),
        .conflicts (conflicts)
    );

    always #10 Clk = ~Clk;

    // SRAM contents as seen by the bench
    function automatic logic [15:0] data_of(input logic [19:0] a);
        if (a == 20'h00010) return 16'hBEEF;
        return a[15:0] ^ 16'h1234;
    endfunction

    assign SRAM_DQ = data_of(SRAM_ADDR);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    // Transaction model: a grant at edge g keeps strobes low until edge g+W,
    // acks at edge g+W, and the arbiter is free again to grant at edge g+W+2.
    int          cyc = 0;
    bit          m_ok = 0;
    bit          busy = 0;
    int          gedge = 0;
    bit          g_c = 0;
    logic [19:0] g_addr = '0;
    int          starve = 0;
    logic        e_str_n = 1'b1;
    logic [19:0] e_addr = '0;
    logic        e_aack = 1'b0, e_cack = 1'b0;
    logic [15:0] e_adata = '0, e_cdata = '0;
    int          e_ag = 0, e_cg = 0, e_cf = 0;

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    always @(posedge Clk) begin
        cyc++;
        if (reset) begin
            busy = 0; starve = 0; e_str_n = 1'b1; e_addr = '0;
            e_aack = 1'b0; e_cack = 1'b0; e_adata = '0; e_cdata = '0;
            e_ag = 0; e_cg = 0; e_cf = 0; m_ok = 1;
        end else begin
            e_aack = 1'b0;
            e_cack = 1'b0;
            if (busy) begin
                if (cyc - gedge == W) begin
                    e_str_n = 1'b1;
                    if (g_c) begin e_cack = 1'b1; e_cdata = data_of(g_addr); end
                    else     begin e_aack = 1'b1; e_adata = data_of(g_addr); end
                end else if (cyc - gedge == W + 1) begin
                    busy = 0;
                end
            end else begin
                if (a_req && c_req) e_cf = sat16(e_cf);
                if (a_req || c_req) begin
                    g_c = c_req && (!a_req || starve == SM);
                    starve = g_c ? 0 : (c_req ? starve + 1 : 0);
                    g_addr = g_c ? c_addr : a_addr;
                    if (g_c) e_cg = sat16(e_cg); else e_ag = sat16(e_ag);
                    e_addr = g_addr; e_str_n = 1'b0; busy = 1; gedge = cyc;
                end else begin
                    starve = 0;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (m_ok) begin
            chk("ce_n", 32'(SRAM_CE_N), 32'(e_str_n));
            chk("oe_n", 32'(SRAM_OE_N), 32'(e_str_n));
            chk("ub_n", 32'(SRAM_UB_N), 32'(e_str_n));
            chk("lb_n", 32'(SRAM_LB_N), 32'(e_str_n));
            chk("we_n", 32'(SRAM_WE_N), 32'(1));
            chk("sram_addr", 32'(SRAM_ADDR), 32'(e_addr));
            chk("a_ack", 32'(a_ack), 32'(e_aack));
            chk("c_ack", 32'(c_ack), 32'(e_cack));
            chk("one_ack", 32'(a_ack & c_ack), 32'(0));
            chk("a_data", 32'(a_data), 32'(e_adata));
            chk("c_data", 32'(c_data), 32'(e_cdata));
`ifdef SRAM_ARB_STATS_EN
            chk("a_grants", 32'(a_grants), 32'(e_ag));
            chk("c_grants", 32'(c_grants), 32'(e_cg));
            chk("conflicts", 32'(conflicts), 32'(e_cf));
`else
            chk("a_grants", 32'(a_grants), 32'(0));
            chk("c_grants", 32'(c_grants), 32'(0));
            chk("conflicts", 32'(conflicts), 32'(0));
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, t, last;
        logic [5:0] order;

        reset = 1'b1; a_req = 1'b0; c_req = 1'b0; a_addr = '0; c_addr = '0;
        step(3);
        chk("rst_oe", 32'(SRAM_OE_N), 32'(1));
        chk("rst_ce", 32'(SRAM_CE_N), 32'(1));
        chk("rst_addr", 32'(SRAM_ADDR), 32'(0));
        chk("rst_acks", 32'({a_ack, c_ack}), 32'(0));
        chk("rst_data", 32'({a_data, c_data}), 32'(0));
        reset = 1'b0;

        // solo A read
        a_req = 1'b1; a_addr = 20'h00010;
        step(1);
        a_req = 1'b0; a_addr = 20'h00077;
        chk("t1_addr", 32'(SRAM_ADDR), 32'h10);
        chk("t1_oe_c1", 32'(SRAM_OE_N), 32'(0));
        step(1);
        chk("t1_oe_c2", 32'(SRAM_OE_N), 32'(0));
        chk("t1_early_ack", 32'(a_ack), 32'(0));
        step(1);
        chk("t1_ack", 32'(a_ack), 32'(1));
        chk("t1_data", 32'(a_data), 32'hBEEF);
        chk("t1_oe_done", 32'(SRAM_OE_N), 32'(1));
        chk("t1_no_c", 32'(c_ack), 32'(0));
        step(1);
        chk("t1_ack_pulse", 32'(a_ack), 32'(0));
        step(2);

        // both requesting: A x4, then forced C, then A
        a_addr = 20'h00001; c_addr = 20'h00002; a_req = 1'b1; c_req = 1'b1;
        n = 0; order = '0;
        for (int i = 0; i < 80 && n < 6; i++) begin
            step(1);
            if (a_ack || c_ack) begin
                order = {order[4:0], c_ack};
                n++;
            end
        end
        a_req = 1'b0; c_req = 1'b0;
        chk("t2_ack_count", 32'(n), 32'(6));
        chk("t2_order", 32'(order), 32'(6'b000010));
        chk("t2_a_data", 32'(a_data), 32'h1235);
        chk("t2_c_data", 32'(c_data), 32'h1236);
        step(2);

        // reset in the second ACCESS cycle aborts the read
        reset = 1'b1; step(1); reset = 1'b0;
        a_req = 1'b1; a_addr = 20'h00033;
        step(1);
        a_req = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        chk("t3_oe", 32'(SRAM_OE_N), 32'(1));
        chk("t3_ce", 32'(SRAM_CE_N), 32'(1));
        chk("t3_ack", 32'(a_ack), 32'(0));
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (a_ack) cnt++;
        end
        chk("t3_no_ack", 32'(cnt), 32'(0));
        chk("t3_a_data", 32'(a_data), 32'(0));

        // one-cycle C request, address changes afterwards
        c_req = 1'b1; c_addr = 20'h0ABCD;
        step(1);
        c_req = 1'b0; c_addr = 20'h00000;
        chk("t4_addr", 32'(SRAM_ADDR), 32'h0ABCD);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (c_ack) cnt++;
        end
        chk("t4_ack_once", 32'(cnt), 32'(1));
        chk("t4_addr_held", 32'(SRAM_ADDR), 32'h0ABCD);
        chk("t4_c_data", 32'(c_data), 32'hB9F9);

        // back-to-back A reads
        a_req = 1'b1; a_addr = 20'h00040;
        n = 0; t = 0; last = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            step(1);
            t++;
            if (a_ack) begin
                if (n > 0) chk("t5_gap", 32'(t - last), 32'(4));
                chk("t5_oe_done", 32'(SRAM_OE_N), 32'(1));
                last = t;
                n++;
            end
        end
        a_req = 1'b0;
        chk("t5_acks", 32'(n), 32'(3));
        step(3);

`ifdef SRAM_ARB_STATS_EN
        // saturation of the A grant counter
        force dut.u_a_grants.count_q = 16'hFFFE;
        release dut.u_a_grants.count_q;
        e_ag = 65534;
        a_req = 1'b1; a_addr = 20'h00005;
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            step(1);
            if (a_ack) n++;
        end
        a_req = 1'b0;
        step(3);
        chk("t6_sat", 32'(a_grants), 32'hFFFF);
`endif

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
